// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the frame-level state encoding
// used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UART_FRAME_BITS = 10;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_byte_transmitter.sv
// Single 8N1 frame serialiser. A start request in IDLE or in the last stop-bit
// cycle launches the next frame with no idle gap between frames.
module uart_byte_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_CYCLES = 33
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] byte_in,
   input  logic                      start,
   output logic                      done,
   output logic                      uart_tx
);

   localparam int                CNT_W         = $clog2(CLK_CYCLES);
   localparam int                BIT_W         = $clog2(UART_FRAME_BITS);
   localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(CLK_CYCLES - 1);
   localparam logic [BIT_W-1:0]  LAST_DATA_BIT = BIT_W'(UART_DATA_BITS);
   localparam logic [BIT_W-1:0]  STOP_BIT      = BIT_W'(UART_FRAME_BITS - 1);

   uart_state_e               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                      tx_q, tx_d;
   logic                      bit_end;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   assign bit_end = (cnt_q == CNT_LAST);
   assign done    = (state_q == STOP) && bit_end;

   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = START;
               bit_d   = '0;
               shreg_d = byte_in;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = BIT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == LAST_DATA_BIT) begin
                  state_d = STOP;
                  bit_d   = STOP_BIT;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               bit_d = '0;
               if (start) begin
                  state_d = START;
                  shreg_d = byte_in;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level follows the next state so the registered output lines up with it.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   assign uart_tx = tx_q;

endmodule

// File: rtl/uart_multibyte_transmitter.sv
// Sends one word as 2^MSG_LOG_WIDTH back-to-back 8N1 frames, byte 0 first,
// after a valid/ack handshake.
module uart_multibyte_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_CYCLES    = 33,
   parameter int MSG_LOG_WIDTH = 2
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [(UART_DATA_BITS<<MSG_LOG_WIDTH)-1:0] data,
   input  logic                                     valid,
   output logic                                     ack,
   output logic                                     busy,
   output logic                                     uart_tx
);

   localparam int               WORD_W    = UART_DATA_BITS << MSG_LOG_WIDTH;
   localparam int               NUM_BYTES = 1 << MSG_LOG_WIDTH;
   localparam int               IDX_W     = (MSG_LOG_WIDTH > 0) ? MSG_LOG_WIDTH : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);

   logic [WORD_W-1:0]         word_q, word_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      busy_q, busy_d;
   logic                      byte_start, byte_done;
   logic [UART_DATA_BITS-1:0] byte_val;

   // NOTE: the word latch is plain datapath, but it is reset anyway so no stale
   // word survives a reset and the whole block restarts from a known state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         idx_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
         busy_q <= busy_d;
      end
   end

   // The byte transmitter is idle exactly when no word is in flight.
   assign ack = valid & ~busy_q;

   always_comb begin
      word_d     = word_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      byte_start = 1'b0;
      byte_val   = data[UART_DATA_BITS-1:0];
      if (ack) begin
         word_d     = data;
         idx_d      = '0;
         busy_d     = 1'b1;
         byte_start = 1'b1;
      end else if (byte_done && (idx_q != LAST_IDX)) begin
         word_d     = word_q >> UART_DATA_BITS;
         idx_d      = idx_q + 1'b1;
         byte_start = 1'b1;
         byte_val   = word_d[UART_DATA_BITS-1:0];
      end else if (byte_done) begin
         idx_d  = '0;
         busy_d = 1'b0;
      end
   end

   uart_byte_transmitter #(
      .CLK_CYCLES (CLK_CYCLES)
   ) u_byte_tx (
      .clk     (clk),
      .reset   (reset),
      .byte_in (byte_val),
      .start   (byte_start),
      .done    (byte_done),
      .uart_tx (uart_tx)
   );

   assign busy = busy_q;

endmodule

// File: tb/tb_uart_multibyte_transmitter.sv
// Self-checking bench: table-driven words, hand-written reset sequences and
// random words, each compared cycle by cycle against an arithmetic line model.
module tb_uart_multibyte_transmitter;

   localparam int CC = 33;
   localparam int LW = 2;
   localparam int NB = 1 << LW;
   localparam int WW = 8 * NB;
   localparam int T  = NB * 10 * CC;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid;
   logic [WW-1:0] data;
   logic          ack;
   logic          busy;
   logic          uart_tx;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [WW-1:0]          w;
      logic [0:NB-1][7:0]     exp;
      logic                   next_valid;
      logic [WW-1:0]          next_w;
      int                     change_at;
      int                     exp_wait;
      string                  tag;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   uart_multibyte_transmitter #(
      .CLK_CYCLES    (CC),
      .MSG_LOG_WIDTH (LW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .data    (data),
      .valid   (valid),
      .ack     (ack),
      .busy    (busy),
      .uart_tx (uart_tx)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected line level k cycles after the accept edge, from frame arithmetic.
   function automatic logic model_bit(input logic [0:NB-1][7:0] exp, input int k);
      int b, byt, pos;
      b   = k / CC;
      byt = b / 10;
      pos = b % 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return exp[byt][pos-1];
   endfunction

   task automatic send_word(input logic [WW-1:0] w, input logic [0:NB-1][7:0] exp,
                            input logic next_valid, input logic [WW-1:0] next_w,
                            input int change_at, input int exp_wait, input string tag);
      int waited = 0;
      int tx_bad = 0;
      int busy_bad = 0;
      int ack_bad = 0;
      int first_bad = -1;
      data  = w;
      valid = 1'b1;
      #1;
      while (ack !== 1'b1 && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check({tag, " ack latency"}, 64'(waited), 64'(exp_wait));
      check({tag, " ack"}, {63'b0, ack}, 64'd1);
      if (ack !== 1'b1) begin
         valid = 1'b0;
         return;
      end
      check({tag, " busy at ack"}, {63'b0, busy}, 64'd0);
      check({tag, " line idle at ack"}, {63'b0, uart_tx}, 64'd1);
      @(posedge clk);
      #1;
      for (int k = 0; k < T; k++) begin
         if (k == change_at) begin
            valid = next_valid;
            data  = next_w;
         end
         @(negedge clk);
         #1;
         if (uart_tx !== model_bit(exp, k)) begin
            tx_bad++;
            if (first_bad < 0) first_bad = k;
         end
         if (busy !== 1'b1) busy_bad++;
         if (ack !== 1'b0) ack_bad++;
      end
      check($sformatf("%s line bad cycles (first %0d)", tag, first_bad), 64'(tx_bad), 64'd0);
      check({tag, " busy low cycles"}, 64'(busy_bad), 64'd0);
      check({tag, " ack while busy"}, 64'(ack_bad), 64'd0);
      @(negedge clk);
      #1;
      check({tag, " busy after word"}, {63'b0, busy}, 64'd0);
      check({tag, " line after word"}, {63'b0, uart_tx}, 64'd1);
      check({tag, " ack in first idle"}, {63'b0, ack}, {63'b0, next_valid});
   endtask

   initial begin
      int bad;
      logic [WW-1:0]      rw;
      logic [0:NB-1][7:0] re;

      vecs[0] = '{32'h12345678, {8'h78, 8'h56, 8'h34, 8'h12}, 1'b0, 32'h0BAD_0BAD, 0,     0, "single"};
      vecs[1] = '{32'hA5A5A5A5, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 1'b1, 32'h00FF00FF, 0,     0, "b2b_first"};
      vecs[2] = '{32'h00FF00FF, {8'hFF, 8'h00, 8'hFF, 8'h00}, 1'b0, 32'h0,        5,     0, "b2b_second"};
      vecs[3] = '{32'hCAFEF00D, {8'h0D, 8'hF0, 8'hFE, 8'hCA}, 1'b1, 32'hDEADBEEF, T / 2, 0, "busy_ignore"};
      vecs[4] = '{32'hDEADBEEF, {8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0, 32'h0,        0,     0, "after_busy"};

      reset = 1'b1;
      valid = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset tx", {63'b0, uart_tx}, 64'd1);
      check("reset busy", {63'b0, busy}, 64'd0);
      check("reset ack", {63'b0, ack}, 64'd0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (uart_tx !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) bad++;
      end
      check("idle after reset bad cycles", 64'(bad), 64'd0);

      for (int i = 0; i < 5; i++) begin
         send_word(vecs[i].w, vecs[i].exp, vecs[i].next_valid, vecs[i].next_w,
                   vecs[i].change_at, vecs[i].exp_wait, vecs[i].tag);
      end

      // Reset asserted between clock edges during byte 2, bit d3.
      data  = 32'h12345678;
      valid = 1'b1;
      #1;
      check("midreset ack", {63'b0, ack}, 64'd1);
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (24 * CC + 11) @(negedge clk);
      #1;
      check("midreset line at d3", {63'b0, uart_tx}, 64'd0);
      check("midreset busy before", {63'b0, busy}, 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check("midreset async tx", {63'b0, uart_tx}, 64'd1);
      check("midreset async busy", {63'b0, busy}, 64'd0);
      check("midreset ack", {63'b0, ack}, 64'd0);
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("post-reset idle bad cycles", 64'(bad), 64'd0);
      send_word(32'h01020304, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b0, 32'h0, 0, 0, "post_reset");

      for (int n = 0; n < 50; n++) begin
         rw = $urandom;
         for (int i = 0; i < NB; i++) re[i] = 8'((rw >> (8 * i)) & 32'hFF);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            #1;
         end
         send_word(rw, re, 1'b0, $urandom, $urandom_range(0, T - 1), 0,
                   $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
